ir_command_transmitter: RTL and testbench

IR_COMMAND_TRANSMITTER -- requirements
Module: ir_command_transmitter

---
 rtl/ir_pkg.sv | 26 ++
 rtl/ir_carrier_gen.sv | 44 ++++
 rtl/ir_command_transmitter.sv | 131 +++++++++++++
 tb/tb_ir_command_transmitter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared IR protocol definitions: FSM encodings, SIRC unit counts and default
// 25 MHz timing constants, common to the rover IR transmitter and receiver.
package ir_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_GAP        = 3'd2,
        S_DATA       = 3'd3,
        S_FRAME_WAIT = 3'd4
    } ir_state_e;

    // SIRC segment lengths in protocol units
    localparam int unsigned START_UNITS = 4;
    localparam int unsigned SPACE_UNITS = 1;
    localparam int unsigned ZERO_UNITS  = 1;
    localparam int unsigned ONE_UNITS   = 2;

    localparam int unsigned CMD_BITS = 12;

    localparam int unsigned DEF_UNIT_CYCLES    = 15000;
    localparam int unsigned DEF_CARRIER_PERIOD = 625;
    localparam int unsigned DEF_FRAME_UNITS    = 75;
    localparam int unsigned DEF_REPEATS        = 3;

endpackage

// File: rtl/ir_carrier_gen.sv
// Registered square-wave carrier; high for the first half of each period,
// phase restarts on every rising edge of enable.
module ir_carrier_gen
    import ir_pkg::*;
#(
    parameter int unsigned CARRIER_PERIOD = DEF_CARRIER_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic carrier
);

    localparam int unsigned PW = $clog2(CARRIER_PERIOD + 1);
    localparam logic [PW-1:0] LAST = PW'(CARRIER_PERIOD - 1);
    localparam logic [PW-1:0] HALF = PW'(CARRIER_PERIOD / 2);

    logic [PW-1:0] phase_q, phase_d;
    logic          en_q;
    logic          carrier_q, carrier_d;

    // enable is the upcoming cycle's mark flag, so a fresh mark gets phase 0
    always_comb begin
        phase_d = '0;
        if (enable && en_q)
            phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
        carrier_d = enable && (phase_d < HALF);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q   <= '0;
            en_q      <= 1'b0;
            carrier_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            en_q      <= enable;
            carrier_q <= carrier_d;
        end
    end

    assign carrier = carrier_q;

endmodule

// File: rtl/ir_command_transmitter.sv
// SIRC-style IR command transmitter: sends a 12-bit rover command REPEATS
// times, LSB first, on a carrier-modulated LED drive.
module ir_command_transmitter
    import ir_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES    = DEF_UNIT_CYCLES,
    parameter int unsigned CARRIER_PERIOD = DEF_CARRIER_PERIOD,
    parameter int unsigned FRAME_UNITS    = DEF_FRAME_UNITS,
    parameter int unsigned REPEATS        = DEF_REPEATS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                send,
    input  logic [CMD_BITS-1:0] command,
    output logic                ir_out,
    output logic                busy,
    output logic                done,
    output logic [2:0]          state
);

    localparam logic [31:0] START_LEN = 32'(START_UNITS * UNIT_CYCLES);
    localparam logic [31:0] SPACE_LEN = 32'(SPACE_UNITS * UNIT_CYCLES);
    localparam logic [31:0] ZERO_LEN  = 32'(ZERO_UNITS * UNIT_CYCLES);
    localparam logic [31:0] ONE_LEN   = 32'(ONE_UNITS * UNIT_CYCLES);
    localparam logic [31:0] FRAME_LEN = 32'(FRAME_UNITS * UNIT_CYCLES);
    localparam logic [3:0]  LAST_BIT  = 4'(CMD_BITS - 1);
    localparam logic [2:0]  LAST_REP  = 3'(REPEATS - 1);

    ir_state_e           state_q, state_d;
    logic [31:0]         unit_q, unit_d;
    logic [31:0]         frame_q, frame_d;
    logic [CMD_BITS-1:0] cmd_q, cmd_d;
    logic [3:0]          bit_q, bit_d;
    logic [2:0]          rep_q, rep_d;

    logic [31:0] mark_len;
    logic        frame_end, fin, accept, mark_en;

    assign mark_len  = cmd_q[bit_q] ? ONE_LEN : ZERO_LEN;
    assign frame_end = (frame_q == FRAME_LEN - 32'd1);
    // last cycle of the final frame period: done and re-accept point
    assign fin       = (state_q == S_FRAME_WAIT) && frame_end && (rep_q == LAST_REP);
    assign accept    = send && ((state_q == S_IDLE) || fin);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            unit_q  <= '0;
            frame_q <= '0;
            cmd_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            frame_q <= frame_d;
            cmd_q   <= cmd_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unit_d  = unit_q + 32'd1;
        frame_d = frame_q + 32'd1;
        cmd_d   = cmd_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        case (state_q)
            S_IDLE: begin
                unit_d  = '0;
                frame_d = '0;
            end
            S_START: begin
                if (unit_q == START_LEN - 32'd1) begin
                    state_d = S_GAP;
                    unit_d  = '0;
                end
            end
            S_GAP: begin
                if (unit_q == SPACE_LEN - 32'd1) begin
                    state_d = S_DATA;
                    unit_d  = '0;
                end
            end
            S_DATA: begin
                if (unit_q == mark_len - 32'd1) begin
                    unit_d  = '0;
                    bit_d   = (bit_q == LAST_BIT) ? 4'd0 : bit_q + 4'd1;
                    state_d = (bit_q == LAST_BIT) ? S_FRAME_WAIT : S_GAP;
                end
            end
            S_FRAME_WAIT: begin
                unit_d = '0;
                if (frame_end) begin
                    frame_d = '0;
                    rep_d   = rep_q + 3'd1;
                    state_d = (rep_q == LAST_REP) ? S_IDLE : S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = S_START;
            cmd_d   = command;
            unit_d  = '0;
            frame_d = '0;
            bit_d   = '0;
            rep_d   = '0;
        end
    end

    // carrier is keyed by the next state so ir_out stays a flop yet is in phase
    always_comb begin
        mark_en = (state_d == S_START) || (state_d == S_DATA);
        done    = fin;
        busy    = (state_q != S_IDLE) && !fin;
        state   = state_q;
    end

    ir_carrier_gen #(
        .CARRIER_PERIOD (CARRIER_PERIOD)
    ) u_carrier (
        .clock   (clock),
        .reset   (reset),
        .enable  (mark_en),
        .carrier (ir_out)
    );

endmodule

// File: tb/tb_ir_command_transmitter.sv
// Directed bench for ir_command_transmitter: waveform, timing, repeat,
// back-to-back and reset-abort behaviour at UNIT=10, carrier period 4.
module tb_ir_command_transmitter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        send  = 1'b0;
    logic [11:0] command = 12'h000;
    logic        ir_out, busy, done;
    logic [2:0]  state;

    ir_command_transmitter #(
        .UNIT_CYCLES    (10),
        .CARRIER_PERIOD (4),
        .FRAME_UNITS    (75),
        .REPEATS        (3)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .send    (send),
        .command (command),
        .ir_out  (ir_out),
        .busy    (busy),
        .done    (done),
        .state   (state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic       tr_ir   [0:2300];
    logic       tr_done [0:2300];
    logic       tr_busy [0:2300];
    logic [2:0] tr_st   [0:2300];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record n cycles after an accepting edge (t=1 is the first cycle after it).
    task automatic capture(input int n, input bit hold, input int poke_t);
        for (int t = 1; t <= n; t++) begin
            @(negedge clock);
            tr_ir[t]   = ir_out;
            tr_done[t] = done;
            tr_busy[t] = busy;
            tr_st[t]   = state;
            if (!hold) send = 1'b0;
            if (t == poke_t) begin
                send    = 1'b1;
                command = 12'hFFF;
            end
        end
    endtask

    // Expected ir_out at offset k from the first start-mark cycle of a frame.
    function automatic logic exp_ir(input logic [11:0] cmd, input int k);
        int p;
        int len;
        if (k < 40) return ((k % 4) < 2);
        p = 40;
        for (int i = 0; i < 12; i++) begin
            if (k < p + 10) return 1'b0;
            p += 10;
            len = cmd[i] ? 20 : 10;
            if (k < p + len) return (((k - p) % 4) < 2);
            p += len;
        end
        return 1'b0;
    endfunction

    // Walk the recorded envelope: a long mark still has carrier 12 cycles in.
    function automatic logic [11:0] decode(input int base);
        logic [11:0] v;
        int p;
        v = '0;
        p = base + 40;
        for (int i = 0; i < 12; i++) begin
            p += 10;
            v[i] = tr_ir[p + 12];
            p += v[i] ? 20 : 10;
        end
        return v;
    endfunction

    task automatic check_frame(input string tag, input logic [11:0] cmd, input int base, input int len);
        int bad;
        bad = 0;
        for (int k = 0; k < len; k++)
            if (tr_ir[base + k] !== exp_ir(cmd, k)) bad++;
        chk(tag, bad, 0);
    endtask

    function automatic int count_done(input int lo, input int hi);
        int c;
        c = 0;
        for (int t = lo; t <= hi; t++) if (tr_done[t] === 1'b1) c++;
        return c;
    endfunction

    initial begin
        int dcnt;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_state", state, 0);
        chk("rst_ir", ir_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", busy, 0);

        // 12'h081, three frames, stray send with FFF during frame 1
        command = 12'h081;
        send    = 1'b1;
        capture(2252, 1'b0, 200);
        chk("a_first_ir", tr_ir[1], 1);
        chk("a_first_busy", tr_busy[1], 1);
        chk("a_first_state", tr_st[1], 1);
        check_frame("a_frame0_wave", 12'h081, 1, 750);
        check_frame("a_frame1_wave", 12'h081, 751, 750);
        check_frame("a_frame2_wave", 12'h081, 1501, 750);
        chk("a_decode0", decode(1), 12'h081);
        chk("a_decode2", decode(1501), 12'h081);
        chk("a_f1_prev_space", tr_ir[750], 0);
        chk("a_f1_start", tr_st[751], 1);
        chk("a_f2_start", tr_st[1501], 1);
        chk("a_done_count", count_done(1, 2252), 1);
        chk("a_done_at_2250", tr_done[2250], 1);
        chk("a_busy_at_done", tr_busy[2250], 0);
        chk("a_busy_before_done", tr_busy[2249], 1);
        chk("a_idle_after", tr_st[2251], 0);
        chk("a_ir_after", tr_ir[2251], 0);

        // send held high: back-to-back transmission of 12'h7FF
        command = 12'h7FF;
        send    = 1'b1;
        capture(2260, 1'b1, 0);
        check_frame("b_frame0_wave", 12'h7FF, 1, 750);
        chk("b_decode0", decode(1), 12'h7FF);
        chk("b_done_at_2250", tr_done[2250], 1);
        chk("b_done_count", count_done(1, 2250), 1);
        chk("b_restart_state", tr_st[2251], 1);
        chk("b_restart_ir", tr_ir[2251], 1);
        chk("b_restart_busy", tr_busy[2251], 1);
        check_frame("b_second_start", 12'h7FF, 2251, 10);
        send  = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("b_abort_state", state, 0);
        reset = 1'b0;

        // reset during cycle 100 of the first frame
        @(negedge clock);
        command = 12'h081;
        send    = 1'b1;
        capture(100, 1'b0, 0);
        chk("c_mark_bit0", tr_ir[51], 1);
        reset = 1'b1;
        @(negedge clock);
        chk("c_ir", ir_out, 0);
        chk("c_busy", busy, 0);
        chk("c_state", state, 0);
        chk("c_done", done, 0);
        reset = 1'b0;
        dcnt  = 0;
        for (int t = 0; t < 2500; t++) begin
            @(negedge clock);
            if (done === 1'b1) dcnt++;
        end
        chk("c_no_done", dcnt, 0);

        // zero command still transmitted, 280-cycle envelope
        command = 12'h000;
        send    = 1'b1;
        capture(300, 1'b0, 0);
        check_frame("d_wave", 12'h000, 1, 300);
        chk("d_decode", decode(1), 12'h000);
        chk("d_last_data", tr_st[280], 3);
        chk("d_frame_wait", tr_st[281], 4);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
